// File: rtl/y86_alu.sv
// y86_alu: 64-bit OPq ALU (add/sub/and/xor) with combinational result and
// flags {ZF,SF,OF}, plus a clocked condition-code register for cmov/jXX.
// Ports: clock, reset (async high) | a, b, ctrl, set_cc in | ans, cond, cc out.
module y86_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ctrl,
    input  logic             set_cc,
    output logic [WIDTH-1:0] ans,
    output logic [2:0]       cond,
    output logic [2:0]       cc
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    localparam int MSB = WIDTH - 1;

    alu_op_e          op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] cin_w;
    logic [WIDTH-1:0] sum;
    logic             is_arith;
    logic             ovf;
    logic [2:0]       cc_d;
    logic [2:0]       cc_q;

    assign op = alu_op_e'(ctrl);

    // Subtract reuses the adder as a + ~b + 1; carry-out is dropped.
    always_comb begin
        b_eff = b;
        cin_w = '0;
        if (op == OP_SUB) begin
            b_eff = ~b;
            cin_w = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        sum = a + b_eff + cin_w;
    end

    always_comb begin
        ans      = sum;
        is_arith = 1'b1;
        unique case (op)
            OP_ADD: begin
                ans      = sum;
                is_arith = 1'b1;
            end
            OP_SUB: begin
                ans      = sum;
                is_arith = 1'b1;
            end
            OP_AND: begin
                ans      = a & b;
                is_arith = 1'b0;
            end
            OP_XOR: begin
                ans      = a ^ b;
                is_arith = 1'b0;
            end
        endcase
    end

    // With b already inverted for sub, one rule covers both add and sub:
    // operands agree in sign but the result does not.
    always_comb begin
        ovf  = is_arith && (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
        cond = {(ans == '0), ans[MSB], ovf};
    end

    always_comb begin
        cc_d = cc_q;
        if (set_cc) begin
            cc_d = cond;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cc_q <= 3'b000;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc = cc_q;

endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu: vector table for the combinational ALU path plus hand-written
// sequences for the condition-code register, checked through scoreboards.
module tb_y86_alu;

    localparam int W = 64;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] XOR = 2'b11;
    localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic [1:0]   ctrl;
    logic         set_cc;
    logic [W-1:0] ans;
    logic [2:0]   cond;
    logic [2:0]   cc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] e_ans;
        logic [2:0]   e_cond;
    } vec_t;

    vec_t vecs[14];

    logic [W+2:0] exp_q[$];
    logic [2:0]   cc_exp_q[$];

    y86_alu #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .ctrl  (ctrl),
        .set_cc(set_cc),
        .ans   (ans),
        .cond  (cond),
        .cc    (cc)
    );

    always #5 clock = ~clock;

    task automatic check_comb(input int idx);
        logic [W+2:0] e;
        e = exp_q.pop_front();
        total++;
        if ({ans, cond} !== e) begin
            bad++;
            $display("FAIL vec%0d: ans=%h cond=%b want ans=%h cond=%b",
                     idx, ans, cond, e[W+2:3], e[2:0]);
        end
    endtask

    task automatic check_cc(input string nm);
        logic [2:0] e;
        e = cc_exp_q.pop_front();
        total++;
        if (cc !== e) begin
            bad++;
            $display("FAIL %s: cc=%b want %b", nm, cc, e);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic sc);
        ctrl   = op;
        a      = va;
        b      = vb;
        set_cc = sc;
    endtask

    initial begin
        vecs[0]  = '{ADD, 64'd5, 64'd3, 64'd8, 3'b000};
        vecs[1]  = '{ADD, '1, 64'd1, 64'd0, 3'b100};
        vecs[2]  = '{SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010};
        vecs[3]  = '{SUB, 64'd5, 64'd5, 64'd0, 3'b100};
        vecs[4]  = '{ADD, MAXP, 64'd1, MINN, 3'b011};
        vecs[5]  = '{SUB, MINN, 64'd1, MAXP, 3'b001};
        vecs[6]  = '{SUB, 64'd0, MINN, MINN, 3'b011};
        vecs[7]  = '{AND, 64'hF0F0, 64'h0FF0, 64'h00F0, 3'b000};
        vecs[8]  = '{XOR, 64'hAAAA, 64'hAAAA, 64'd0, 3'b100};
        vecs[9]  = '{AND, MINN, MINN, MINN, 3'b010};
        vecs[10] = '{XOR, 64'h8000_0000_0000_0001, 64'd1, MINN, 3'b010};
        vecs[11] = '{ADD, MINN, MINN, 64'd0, 3'b101};
        vecs[12] = '{SUB, 64'd1, 64'd2, '1, 3'b010};
        vecs[13] = '{XOR, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000,
                     64'hEDCB_5678_6543_DEF0, 3'b010};

        reset = 1'b1;
        drive(ADD, '0, '0, 1'b0);
        #2;
        cc_exp_q.push_back(3'b000);
        check_cc("reset_state");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            drive(vecs[i].op, vecs[i].va, vecs[i].vb, 1'b0);
            exp_q.push_back({vecs[i].e_ans, vecs[i].e_cond});
            #1;
            check_comb(i);
        end

        @(negedge clock);
        cc_exp_q.push_back(3'b000);
        check_cc("cc_hold_after_vectors");

        drive(SUB, 64'd5, 64'd5, 1'b1);
        #1;
        cc_exp_q.push_back(3'b000);
        check_cc("cc_before_edge");
        @(posedge clock);
        #1;
        cc_exp_q.push_back(3'b100);
        check_cc("cc_load_sub");

        @(negedge clock);
        drive(ADD, 64'd1, 64'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            cc_exp_q.push_back(3'b100);
            check_cc("cc_hold");
        end

        @(negedge clock);
        reset = 1'b1;
        #1;
        cc_exp_q.push_back(3'b000);
        check_cc("async_reset");
        reset = 1'b0;

        drive(ADD, MAXP, 64'd1, 1'b1);
        @(posedge clock);
        #1;
        cc_exp_q.push_back(3'b011);
        check_cc("cc_load_ovf");

        @(negedge clock);
        drive(XOR, 64'h55, 64'h55, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cc_exp_q.push_back(3'b000);
        check_cc("reset_wins");

        @(negedge clock);
        reset = 1'b0;
        drive(SUB, MINN, 64'd1, 1'b1);
        @(posedge clock);
        #1;
        cc_exp_q.push_back(3'b001);
        check_cc("cc_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

endmodule
